// File: rtl/s_term_wire_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s_term_bist_pkg
// Description : Shared constants, state encoding and pattern helpers for the
//               south-terminal wire loop-back self-test.
//               pattern(v)   - northbound test vector v in flat tx order
//               expected(tx) - southbound value an ideal NE terminal returns
// Revision    : 1.0 - initial release
// ============================================================================
package s_term_bist_pkg;

    localparam int W_SINGLE    = 4;
    localparam int W_DOUBLE    = 8;
    localparam int W_DOUBLEB   = 8;
    localparam int W_QUAD      = 16;
    localparam int TOTAL_WIRES = W_SINGLE + W_DOUBLE + W_DOUBLEB + W_QUAD;
    localparam int NUM_VECTORS = 38;

    // Group base offsets inside the flat 36-bit tx/rx vectors.
    localparam int B_SINGLE  = 0;
    localparam int B_DOUBLE  = B_SINGLE + W_SINGLE;
    localparam int B_DOUBLEB = B_DOUBLE + W_DOUBLE;
    localparam int B_QUAD    = B_DOUBLEB + W_DOUBLEB;

    localparam logic [5:0] FIRST_FAIL_NONE = 6'd63;
    localparam logic [5:0] LAST_VECTOR     = 6'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Vector 0 all zeros, 1..36 walking one on flat bit v-1, 37 all ones.
    function automatic logic [TOTAL_WIRES-1:0] pattern(input logic [5:0] v);
        logic [TOTAL_WIRES-1:0] p;
        if (v == 6'd0)
            p = '0;
        else if (v == LAST_VECTOR)
            p = '1;
        else
            p = TOTAL_WIRES'(1) << (v - 6'd1);
        return p;
    endfunction

    // The far terminal reflects every group index-mirrored: rx[i] = tx[W-1-i].
    function automatic logic [TOTAL_WIRES-1:0] expected(input logic [TOTAL_WIRES-1:0] tx);
        logic [TOTAL_WIRES-1:0] e;
        e = '0;
        for (int i = 0; i < W_SINGLE; i++)
            e[B_SINGLE + i] = tx[B_SINGLE + W_SINGLE - 1 - i];
        for (int i = 0; i < W_DOUBLE; i++)
            e[B_DOUBLE + i] = tx[B_DOUBLE + W_DOUBLE - 1 - i];
        for (int i = 0; i < W_DOUBLEB; i++)
            e[B_DOUBLEB + i] = tx[B_DOUBLEB + W_DOUBLEB - 1 - i];
        for (int i = 0; i < W_QUAD; i++)
            e[B_QUAD + i] = tx[B_QUAD + W_QUAD - 1 - i];
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_term_wire_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : s_term_wire_bist_if
// Description : Fabric wires and control/status bundle of the south-terminal
//               loop-back self-test.
//               master : BIST side (drives N*BEG and status, samples S*)
//               slave  : fabric/controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface s_term_wire_bist_if;
    logic        start;
    logic [3:0]  N1BEG;
    logic [7:0]  N2BEG;
    logic [7:0]  N2BEGb;
    logic [15:0] N4BEG;
    logic [3:0]  S1END;
    logic [7:0]  S2MID;
    logic [7:0]  S2END;
    logic [15:0] S4END;
    logic        busy;
    logic        done;
    logic        pass;
    logic [35:0] err_mask;
    logic [5:0]  err_count;
    logic [5:0]  first_fail;

    modport master (
        input  start, S1END, S2MID, S2END, S4END,
        output N1BEG, N2BEG, N2BEGb, N4BEG,
               busy, done, pass, err_mask, err_count, first_fail
    );

    modport slave (
        output start, S1END, S2MID, S2END, S4END,
        input  N1BEG, N2BEG, N2BEGb, N4BEG,
               busy, done, pass, err_mask, err_count, first_fail
    );
endinterface
`default_nettype wire

// File: rtl/s_term_wire_bist_sync.sv
`default_nettype none
// ============================================================================
// Module      : term_sync2
// Description : Free-running 2-flop synchroniser, asynchronous active-high
//               reset to zero.
//               clk, rst : clock and reset
//               d        : asynchronous input bus
//               q        : second-stage (synchronised) output
// Revision    : 1.0 - initial release
// ============================================================================
module term_sync2 #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/s_term_wire_bist.sv
`default_nettype none
// ============================================================================
// Module      : s_term_wire_bist
// Description : South-edge wire loop-back self-test. Drives 38 vectors on the
//               northbound wires, samples the mirrored southbound return after
//               SETTLE_CYCLES and accumulates pass/fail diagnostics.
//               UserCLK, Reset : clock, asynchronous active-high reset
//               bus (master)   : start, N*BEG out, S* in, busy/done/pass,
//                                err_mask, err_count, first_fail
// Revision    : 1.0 - initial release
// ============================================================================
import s_term_bist_pkg::*;

module s_term_wire_bist #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  UserCLK,
    input  logic                  Reset,
    s_term_wire_bist_if.master    bus
);

    localparam int                c_cnt_w    = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [5:0]               r_vec;
    logic [TOTAL_WIRES-1:0]   r_tx;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic [TOTAL_WIRES-1:0]   r_err_mask;
    logic [5:0]               r_err_count;
    logic [5:0]               r_first_fail;

    logic [TOTAL_WIRES-1:0]   w_rx_raw;
    logic [TOTAL_WIRES-1:0]   w_rx_sync;
    logic [TOTAL_WIRES-1:0]   w_diff;
    logic                     w_fail;
    logic [5:0]               w_err_count_next;
    logic                     w_start_run;
    logic                     w_check;

    assign w_rx_raw = {bus.S4END, bus.S2END, bus.S2MID, bus.S1END};

    term_sync2 #(
        .WIDTH (TOTAL_WIRES)
    ) u_sync (
        .clk (UserCLK),
        .rst (Reset),
        .d   (w_rx_raw),
        .q   (w_rx_sync)
    );

    // r_tx still holds the vector under test during CHECK.
    assign w_diff           = w_rx_sync ^ expected(r_tx);
    assign w_fail           = |w_diff;
    assign w_err_count_next = (w_fail && (r_err_count != 6'd63)) ? r_err_count + 6'd1
                                                                 : r_err_count;

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_start_run  = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == c_cnt_last)
                    w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_check      = 1'b1;
                w_state_next = (r_vec == LAST_VECTOR) ? ST_DONE : ST_SETTLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_cnt        <= '0;
            r_vec        <= '0;
            r_tx         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_mask   <= '0;
            r_err_count  <= '0;
            r_first_fail <= FIRST_FAIL_NONE;
        end else if (w_start_run) begin
            r_cnt        <= '0;
            r_vec        <= 6'd0;
            r_tx         <= pattern(6'd0);
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_mask   <= '0;
            r_err_count  <= '0;
            r_first_fail <= FIRST_FAIL_NONE;
        end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_check) begin
            r_cnt       <= '0;
            r_err_mask  <= r_err_mask | w_diff;
            r_err_count <= w_err_count_next;
            if (w_fail && (r_first_fail == FIRST_FAIL_NONE))
                r_first_fail <= r_vec;
            if (r_vec == LAST_VECTOR) begin
                r_tx   <= '0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_count_next == 6'd0);
            end else begin
                r_vec <= r_vec + 6'd1;
                r_tx  <= pattern(r_vec + 6'd1);
            end
        end
    end

    assign bus.N1BEG      = r_tx[B_SINGLE  +: W_SINGLE];
    assign bus.N2BEG      = r_tx[B_DOUBLE  +: W_DOUBLE];
    assign bus.N2BEGb     = r_tx[B_DOUBLEB +: W_DOUBLEB];
    assign bus.N4BEG      = r_tx[B_QUAD    +: W_QUAD];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_mask   = r_err_mask;
    assign bus.err_count  = r_err_count;
    assign bus.first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_s_term_wire_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_term_wire_bist
// Description : Self-checking bench for s_term_wire_bist. A far-terminal
//               loop-back with injectable stuck-at / swap faults closes the
//               wires; results are compared with a vector-by-vector model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_term_wire_bist;

    localparam int S          = 4;
    localparam int RUN_CYCLES = 38 * (S + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s_term_wire_bist_if bus();

    s_term_wire_bist #(
        .SETTLE_CYCLES (S)
    ) dut (
        .UserCLK (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Fault configuration of the loop-back
    logic [35:0] f_s0 = '0;
    logic [35:0] f_s1 = '0;
    bit          f_sw = 1'b0;
    int          f_a  = 0;
    int          f_b  = 0;

    logic [35:0] w_tx;
    logic [35:0] w_rx;

    // Ideal far terminal: each rx wire returns the tx wire at the mirrored
    // position of its own group.
    function automatic logic [35:0] mirror(input logic [35:0] tx);
        logic [35:0] rx;
        int base;
        int w;
        for (int i = 0; i < 36; i++) begin
            if (i < 4)       begin base = 0;  w = 4;  end
            else if (i < 12) begin base = 4;  w = 8;  end
            else if (i < 20) begin base = 12; w = 8;  end
            else             begin base = 20; w = 16; end
            rx[i] = tx[base + w - 1 - (i - base)];
        end
        return rx;
    endfunction

    function automatic logic [35:0] apply_fault(input logic [35:0] ideal, input logic [35:0] s0,
                                                input logic [35:0] s1, input bit sw,
                                                input int a, input int b);
        logic [35:0] r;
        logic [35:0] t;
        r = (ideal & ~s0) | s1;
        if (sw) begin
            t    = r;
            r[a] = t[b];
            r[b] = t[a];
        end
        return r;
    endfunction

    function automatic logic [35:0] tx_of(input int v);
        logic [35:0] t;
        if (v == 0)       t = '0;
        else if (v == 37) t = '1;
        else              t = 36'd1 << (v - 1);
        return t;
    endfunction

    assign w_tx = {bus.N4BEG, bus.N2BEGb, bus.N2BEG, bus.N1BEG};
    always_comb w_rx = apply_fault(mirror(w_tx), f_s0, f_s1, f_sw, f_a, f_b);
    assign {bus.S4END, bus.S2END, bus.S2MID, bus.S1END} = w_rx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-run outcome computed vector by vector from the fault definition.
    task automatic model(input logic [35:0] s0, input logic [35:0] s1, input bit sw,
                         input int a, input int b,
                         output bit pass, output int cnt, output int ff, output logic [35:0] mask);
        logic [35:0] ideal;
        logic [35:0] d;
        cnt  = 0;
        ff   = 63;
        mask = '0;
        for (int v = 0; v < 38; v++) begin
            ideal = mirror(tx_of(v));
            d     = apply_fault(ideal, s0, s1, sw, a, b) ^ ideal;
            if (d != 0) begin
                mask = mask | d;
                if (cnt < 63) cnt++;
                if (ff == 63) ff = v;
            end
        end
        pass = (cnt == 0);
    endtask

    // Start a run; optionally raise start during the run at a given cycle offset.
    task automatic do_run(input int pulse_at, input bit exp_pass, input int exp_cnt,
                          input int exp_ff, input logic [35:0] exp_mask);
        int cycles;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_at_accept", bus.busy, 1);
        chk("done_cleared", bus.done, 0);
        chk("count_cleared", bus.err_count, 0);
        chk("first_fail_init", bus.first_fail, 63);
        chk("mask_cleared", bus.err_mask, 0);
        chk("vec0_tx", w_tx, 0);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            bus.start = (cycles == pulse_at);
        end
        bus.start = 1'b0;
        chk("done_latency", cycles, RUN_CYCLES);
        chk("busy_at_done", bus.busy, 0);
        chk("pass", bus.pass, exp_pass);
        chk("err_count", bus.err_count, exp_cnt);
        chk("first_fail", bus.first_fail, exp_ff);
        chk("err_mask", bus.err_mask, exp_mask);
        @(posedge clk);
        #1;
        chk("done_held", bus.done, 1);
        chk("idle_after_done", bus.busy, 0);
    endtask

    typedef struct {
        logic [35:0] s0;
        logic [35:0] s1;
        bit          sw;
        int          a;
        int          b;
        int          pulse_at;
        bit          exp_pass;
        int          exp_cnt;
        int          exp_ff;
        logic [35:0] exp_mask;
    } vec_t;

    vec_t tbl [4];

    initial begin
        bit          m_pass;
        int          m_cnt;
        int          m_ff;
        logic [35:0] m_mask;
        int          kind;

        // Ideal, with start pulsed in SETTLE of vector 5 (edge k+27)
        tbl[0] = '{36'h0, 36'h0, 1'b0, 0, 0, 26, 1'b1, 0, 63, 36'h0};
        // S4END5 stuck at 0
        tbl[1] = '{36'h1 << 25, 36'h0, 1'b0, 0, 0, -1, 1'b0, 2, 31, 36'h1 << 25};
        // S1END0/S1END1 swapped, start during the final CHECK cycle
        tbl[2] = '{36'h0, 36'h0, 1'b1, 0, 1, RUN_CYCLES - 1, 1'b0, 2, 3, 36'h3};
        // S1END0 stuck at 1
        tbl[3] = '{36'h0, 36'h1, 1'b0, 0, 0, -1, 1'b0, 36, 0, 36'h1};

        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", w_tx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_mask", bus.err_mask, 0);
        chk("rst_count", bus.err_count, 0);
        chk("rst_first_fail", bus.first_fail, 63);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            f_s0 = tbl[i].s0;
            f_s1 = tbl[i].s1;
            f_sw = tbl[i].sw;
            f_a  = tbl[i].a;
            f_b  = tbl[i].b;
            do_run(tbl[i].pulse_at, tbl[i].exp_pass, tbl[i].exp_cnt, tbl[i].exp_ff, tbl[i].exp_mask);
        end

        for (int r = 0; r < 8; r++) begin
            kind = $urandom_range(0, 3);
            f_s0 = '0;
            f_s1 = '0;
            f_sw = 1'b0;
            f_a  = $urandom_range(0, 35);
            f_b  = $urandom_range(0, 35);
            case (kind)
                0: f_s0 = 36'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
                1: f_s0[f_a] = 1'b1;
                2: f_s1[f_a] = 1'b1;
                default: f_sw = 1'b1;
            endcase
            model(f_s0, f_s1, f_sw, f_a, f_b, m_pass, m_cnt, m_ff, m_mask);
            do_run(-1, m_pass, m_cnt, m_ff, m_mask);
        end

        // Asynchronous reset while vector 10 is on the wires
        f_s0 = '0;
        f_s1 = '0;
        f_sw = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        chk("vec10_tx", w_tx, 36'd1 << 9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", w_tx, 0);
        chk("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_first_fail", bus.first_fail, 63);
        do_run(-1, 1'b1, 0, 63, 36'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
